boot_loader: RTL and testbench
==============================

# boot_loader

Byte-stream program loader sitting directly upstream of the 8-bit microcontroller's instruction memory. It accepts a framed program image over an 8-bit valid/ready byte interface and writes it word-by-word into the 16-bit instruction store at addresses 0..N-1. It drives the core's `bootstrapping` hold signal, releasing the core only after a complete image with a correct checksum has been written.

## Interface
Parameters:
- `ADDR_W`, 12, instruction memory address width (matches the core's `pc_out`).
- `DATA_W`, 16, instruction word width; fixed at 2 bytes, high byte first.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured in IDLE, DONE and ERROR only.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data, `{hi_byte, lo_byte}`.
- `bootstrapping`  out  1  high holds the core in boot; low releases it.
- `done`  out  1  level; a valid image has been loaded.
- `err`  out  1  level; the last load failed.

## Operation
- Frame format: LEN_HI, LEN_LO, then LEN pairs of (HI, LO), then CK.
  - LEN = `{LEN_HI[3:0], LEN_LO}`, 0..4095 words.
  - LEN_HI[7:4] != 0 is a framing error.
- Checksum: CK must equal the mod-256 sum of every preceding byte in the frame, including both LEN bytes. An 8-bit accumulator wraps silently.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR: `start` → LEN_HI. This clears the accumulator, word counter, `done` and `err`, and sets `bootstrapping` to 1.
  - LEN_HI: on transfer, if the upper nibble is nonzero → ERROR; otherwise latch the byte → LEN_LO.
  - LEN_LO: on transfer, if LEN == 0 → CHECK; otherwise → DATA_HI.
  - DATA_HI: latch the high byte → DATA_LO.
  - DATA_LO: issue a write at address = word counter, then increment the counter. If the counter has reached LEN-1 → CHECK; otherwise → DATA_HI.
  - CHECK: on transfer, if CK == accumulator → DONE; otherwise → ERROR.
- `byte_ready` = 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. It is decoded from the state register, with no combinational path from `byte_valid`.
- With `byte_valid` low, the state and all counters hold. Bytes presented while `byte_ready` is 0 are not consumed.
- `bootstrapping` = 0 only in DONE. ERROR keeps the core held.
- `start` asserted in any loading state is ignored.
- `rst` at any time returns the block to IDLE. Memory words already written are not undone.
- The word counter is ADDR_W+1 bits wide so that LEN = 4095 terminates without wrap. `mem_addr` is its low ADDR_W bits.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `bootstrapping` = 1, `done` = 0, `err` = 0.
- `byte_ready` rises the cycle after `start` is sampled.
- One byte can be accepted every cycle, giving a peak rate of one memory write per 2 cycles.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid the cycle after the DATA_LO transfer, and `mem_we` is high for exactly that one cycle.
- `done` rises and `bootstrapping` falls the cycle after the CK transfer. The last `mem_we` (if any) precedes or coincides with that edge.
- `err` rises the cycle after the offending byte is accepted (LEN_HI or CK). `byte_ready` is 0 from that same cycle.
- `rst` and `start` asserted in the same cycle: `rst` wins.

## Test plan
- Stream 00 03 60 FF 61 FF 82 10 54, back-to-back → writes 0x60FF@0, 0x61FF@1, 0x8210@2 on 3 single-cycle strobes; `done` = 1, `bootstrapping` = 0, `err` = 0.
- Same stream with CK = 0x55 → the 3 writes still occur; `err` = 1, `bootstrapping` = 1, `done` = 0. A following `start` plus the correct stream → `done`.
- Stream 10 … → ERROR the cycle after the first byte; no `mem_we`; `byte_ready` = 0.
- Stream 00 00 00 → zero writes; `done` = 1 the cycle after the third byte.
- Correct 3-word stream with `byte_valid` toggled randomly → identical writes and final state; no byte is consumed while `byte_ready` = 0.
- `rst` after the first word is written, then `start` and the full 3-word stream → writes restart at address 0; `bootstrapping` stays 1 until the new CK is accepted.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader
//   Receives a framed program image over an 8-bit valid/ready byte stream and
//   writes it word-by-word into the 16-bit instruction store, starting at
//   address 0. The core stays held in boot until a complete image with a
//   matching checksum has been written.
//
//   Frame: LEN_HI, LEN_LO, LEN x (HI, LO), CK
//     LEN = {LEN_HI[3:0], LEN_LO}. A nonzero LEN_HI[7:4] is a framing error.
//     CK  = mod-256 sum of every earlier byte in the frame.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a load (honoured in IDLE / DONE / ERROR)
//   byte_valid/data   incoming stream byte
//   byte_ready        loader can take a byte this cycle
//   mem_we/addr/wdata registered instruction-store write port
//   bootstrapping     1 holds the core, 0 releases it (DONE only)
//   done / err        level status of the most recent load
module boot_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              bootstrapping,
    output logic              done,
    output logic              err
);

    // Extra counter bit lets LEN = 4095 finish without the count wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam int LEN_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              boot_q, boot_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        acc_sum;

    // Ready is a pure state decode, so it never depends on byte_valid.
    assign byte_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                        (state_q == S_CHECK);

    assign xfer    = byte_valid && byte_ready;
    assign cnt_inc = cnt_q + 1'b1;
    assign acc_sum = acc_q + byte_data;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        boot_d      = boot_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    acc_d   = '0;
                    cnt_d   = '0;
                    boot_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (byte_data[7:4] != 4'h0) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        len_d[11:8] = byte_data[3:0];
                        acc_d       = acc_sum;
                        state_d     = S_LEN_LO;
                    end
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    acc_d      = acc_sum;
                    // Empty image goes straight to the checksum byte.
                    if ({len_q[11:8], byte_data} == '0) state_d = S_CHECK;
                    else                                state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    acc_d   = acc_sum;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = {hi_q, byte_data};
                    cnt_d       = cnt_inc;
                    acc_d       = acc_sum;
                    // Old count == LEN-1 is the same as new count == LEN.
                    if (cnt_inc == CNT_W'(len_q)) state_d = S_CHECK;
                    else                          state_d = S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (byte_data == acc_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        boot_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            boot_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            boot_q      <= boot_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign bootstrapping = boot_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: expected memory writes are queued when a stream is
// launched and a monitor pops/compares each mem_we strobe.
module tb_boot_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              bootstrapping;
    logic              done;
    logic              err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_xfer = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .bootstrapping(bootstrapping), .done(done), .err(err)
    );

    always @(posedge clk) if (byte_valid && byte_ready) n_xfer++;

    // Write scoreboard: every strobe must match the next queued write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got %h@%h, none expected", mem_wdata, mem_addr);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got %h@%h, want %h@%h",
                             mem_wdata, mem_addr, e[DATA_W-1:0], e[ADDR_W+DATA_W-1:DATA_W]);
                end
            end
        end
    end

    // All tasks start and end on a negedge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: byte_ready=%b, want 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: byte_ready=%b, want 1", byte_ready);
        end
    endtask

    task automatic push_good_writes();
        exp_q.push_back({12'd0, 16'h60FF});
        exp_q.push_back({12'd1, 16'h61FF});
        exp_q.push_back({12'd2, 16'h8210});
    endtask

    task automatic check_status(input string name, input logic d, input logic e, input logic b);
        n_chk++;
        if ({done, err, bootstrapping} !== {d, e, b}) begin
            n_fail++;
            $display("FAIL %s: done/err/boot=%b%b%b, want %b%b%b", name, done, err, bootstrapping, d, e, b);
        end
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes: %0d writes missing, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h wdata=%h, want 0",
                     byte_ready, mem_we, mem_addr, mem_wdata);
        end
        check_status("reset_status", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_good_stream();
        logic [7:0] s[$] = '{8'h00, 8'h03, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'h82, 8'h10, 8'h54};
        pulse_start();
        push_good_writes();
        send_stream(s, 1'b0);
        check_status("good_done", 1'b1, 1'b0, 1'b0);
        check_drained("good");
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$] = '{8'h00, 8'h03, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'h82, 8'h10, 8'h55};
        logic [7:0] g[$] = '{8'h00, 8'h03, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'h82, 8'h10, 8'h54};
        pulse_start();
        push_good_writes();
        send_stream(s, 1'b0);
        check_status("badck_err", 1'b0, 1'b1, 1'b1);
        check_drained("badck");
        // Recovery; a start pulse mid-load must be ignored.
        pulse_start();
        push_good_writes();
        send_stream(g[0:3], 1'b0);
        pulse_start();
        send_stream(g[4:8], 1'b0);
        check_status("recover_done", 1'b1, 1'b0, 1'b0);
        check_drained("recover");
    endtask

    task automatic test_bad_len();
        int x0;
        pulse_start();
        x0 = n_xfer;
        send_byte(8'h10, 1'b0);
        check_status("badlen_err", 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL badlen_ready: byte_ready=%b, want 0", byte_ready);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        repeat (5) @(negedge clk);
        byte_valid = 1'b0;
        n_chk++;
        if (n_xfer - x0 != 1) begin
            n_fail++;
            $display("FAIL badlen_consumed: %0d bytes, want 1", n_xfer - x0);
        end
        check_status("badlen_hold", 1'b0, 1'b1, 1'b1);
        check_drained("badlen");
    endtask

    task automatic test_empty_image();
        logic [7:0] s[$] = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_stream(s, 1'b0);
        check_status("empty_done", 1'b1, 1'b0, 1'b0);
        check_drained("empty");
    endtask

    task automatic test_random_valid();
        logic [7:0] s[$] = '{8'h00, 8'h03, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'h82, 8'h10, 8'h54};
        int x0;
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            push_good_writes();
            x0 = n_xfer;
            send_stream(s, 1'b1);
            check_status("rand_done", 1'b1, 1'b0, 1'b0);
            // Valid held in DONE must not be consumed.
            byte_valid = 1'b1;
            repeat (3) @(negedge clk);
            byte_valid = 1'b0;
            n_chk++;
            if (n_xfer - x0 != 9) begin
                n_fail++;
                $display("FAIL rand_consumed: %0d bytes, want 9", n_xfer - x0);
            end
            check_drained("rand");
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] s[$] = '{8'h00, 8'h03, 8'h60, 8'hFF, 8'h61, 8'hFF, 8'h82, 8'h10, 8'h54};
        pulse_start();
        exp_q.push_back({12'd0, 16'h60FF});
        send_stream(s[0:3], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;                 // reset must win over start
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        n_chk++;
        if (byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wins: byte_ready=%b, want 0", byte_ready);
        end
        check_status("rst_status", 1'b0, 1'b0, 1'b1);
        check_drained("rst_first");
        pulse_start();
        push_good_writes();
        send_stream(s[0:7], 1'b0);
        check_status("rst_hold", 1'b0, 1'b0, 1'b1);
        send_byte(s[8], 1'b0);
        check_status("rst_done", 1'b1, 1'b0, 1'b0);
        check_drained("rst_reload");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_good_stream();
        test_bad_checksum();
        test_bad_len();
        test_empty_image();
        test_random_valid();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
